// File: rtl/afifo_rd_pkg.sv
// Shared types and defaults for the async-FIFO read-side stream adapter.
package afifo_rd_pkg;

  // Aligned with MAX_EMPTY_RETRY used by the FIFO test environment.
  localparam int EMPTY_TIMEOUT_DEFAULT = 16;

  typedef logic [1:0] rd_level_t;

  // Encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } rd_state_t;

  function automatic rd_level_t state_level(input rd_state_t s);
    return rd_level_t'(s);
  endfunction

endpackage

// File: rtl/afifo_rd_watchdog.sv
// Stall watchdog: counts enabled cycles, pulses once every TIMEOUT of them,
// clear has priority. Reused for full-stall detection on the write side.
module afifo_rd_watchdog #(
  parameter  int TIMEOUT = 16,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_pulse
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_enable) begin
      if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
        r_cnt   <= '0;
        r_pulse <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
        r_pulse <= 1'b0;
      end
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/afifo_rd_stream_adapter.sv
// Async-FIFO read-side consumer: 2-entry skid buffer onto a valid/ready stream,
// empty-stall watchdog and synchronous flush. Optional AFIFO_RD_ADAPTER_STATS_EN.
module afifo_rd_stream_adapter
  import afifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int EMPTY_TIMEOUT = EMPTY_TIMEOUT_DEFAULT
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [1:0]            level,
  output logic                  empty_timeout
`ifdef AFIFO_RD_ADAPTER_STATS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [15:0]           drop_count
`endif
);

  rd_state_t             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_entry0, r_entry1;
  logic [DATA_WIDTH-1:0] w_entry0_nxt, w_entry1_nxt;
  logic                  w_push, w_pop;
  rd_level_t             w_level;

  assign w_level = state_level(r_state);
  assign m_valid = (r_state != S_EMPTY);
  assign m_data  = r_entry0;
  assign level   = w_level;

  // Read strobe never depends on m_ready; the skid slot absorbs a stalled pop.
  assign rinc   = !rempty && (r_state != S_TWO) && !flush && rrst_n;
  assign w_push = rinc;
  assign w_pop  = m_valid && m_ready;

  // NOTE: every always_comb output gets a default first so no path holds a
  // stale value, which would infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_entry0_nxt = r_entry0;
    w_entry1_nxt = r_entry1;
    unique case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt  = S_ONE;
          w_entry0_nxt = rdata;
        end
      end
      S_ONE: begin
        if (w_push && !w_pop) begin
          w_state_nxt  = S_TWO;
          w_entry1_nxt = rdata;
        end else if (w_pop && !w_push) begin
          w_state_nxt  = S_EMPTY;
        end else if (w_push && w_pop) begin
          w_entry0_nxt = rdata;
        end
      end
      S_TWO: begin
        if (w_pop) begin
          w_state_nxt  = S_ONE;
          w_entry0_nxt = r_entry1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end
  end

  // NOTE: the two data entries are reset too, because m_data must read 0
  // after reset; a deeper buffer would leave its storage unreset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state  <= S_EMPTY;
      r_entry0 <= '0;
      r_entry1 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_entry0 <= w_entry0_nxt;
      r_entry1 <= w_entry1_nxt;
    end
  end

  logic w_wd_enable, w_wd_clear;

  assign w_wd_enable = (r_state == S_EMPTY) && rempty && m_ready;
  assign w_wd_clear  = w_push || flush || !m_ready;

  afifo_rd_watchdog #(
    .TIMEOUT (EMPTY_TIMEOUT)
  ) u_watchdog (
    .clk      (rclk),
    .rst_n    (rrst_n),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_pulse  (empty_timeout)
  );

`ifdef AFIFO_RD_ADAPTER_STATS_EN
  logic [31:0] r_rd_count;
  logic [15:0] r_drop_count;
  logic [16:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_count} + {15'd0, w_level};

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rd_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (flush) begin
        r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  assign rd_count   = r_rd_count;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: doc/afifo_rd_stream_adapter.md
Name: afifo_rd_stream_adapter

Overview:
- Read-side consumer of the async FIFO, in the rclk domain.
- Drives rinc from rempty and presents FIFO words as a valid/ready stream (m_valid/m_ready/m_data) through a 2-entry skid buffer.
- Adds an empty-stall watchdog and a synchronous flush; replaces the read driver in integrated builds.

Parameters:
- DATA_WIDTH, 8, width of rdata/m_data
- EMPTY_TIMEOUT, 16, consecutive starved cycles before empty_timeout pulses (>=2)
- TO_W, $clog2(EMPTY_TIMEOUT+1), watchdog counter width (derived, not overridden)

Ports:
- rclk  input  1  read-domain clock; the block's single clock
- rrst_n  input  1  asynchronous, active-low reset
- rempty  input  1  FIFO empty flag, registered in rclk domain
- rdata  input  DATA_WIDTH  FIFO head word, valid whenever rempty=0
- rinc  output  1  FIFO read strobe; word consumed at the rclk edge where rinc=1
- m_data  output  DATA_WIDTH  stream data
- m_valid  output  1  stream valid
- m_ready  input  1  downstream ready
- flush  input  1  synchronous discard of buffered words
- level  output  2  buffered words, 0..2
- empty_timeout  output  1  one-cycle starvation pulse

Behaviour:
- Reset (async on rrst_n low, released synchronously by the environment):
  - rinc=0, m_valid=0, m_data=0, level=0, empty_timeout=0
  - watchdog=0, state=S_EMPTY
  - Reset mid-transfer drops buffered words; no rinc while rrst_n=0.
- Read request: rinc = !rempty && (level!=2) && !flush && rrst_n. Combinational from registers and rempty only; no path from m_ready.
- Push: rinc=1 at an edge -> rdata captured into the buffer at that edge (zero read latency).
- Pop: m_valid && m_ready at an edge.
- Buffer: entry0 drives m_data; entry1 is the skid slot; m_valid = (level!=0).
- State machine:
  - S_EMPTY(level 0): push -> S_ONE.
  - S_ONE(level 1): push&!pop -> S_TWO; pop&!push -> S_EMPTY; push&pop -> S_ONE, entry0<=rdata.
  - S_TWO(level 2): pop -> S_ONE, entry0<=entry1. No push in S_TWO.
- Throughput: with m_ready=1 and rempty=0 continuously, one word per cycle after a 1-cycle fill latency (first m_valid one cycle after first rinc).
- Ordering: strict FIFO order; no word duplicated or dropped except by flush/reset.
- m_data stable while m_valid=1 && m_ready=0 (AXI-style hold); m_valid never drops without a pop.
- flush=1: next edge level=0, m_valid=0, watchdog=0; rinc held 0 that cycle. Flush beats a simultaneous pop (popped word is still discarded). Flush does not touch the FIFO.
- Watchdog:
  - Increments when level==0 && rempty && m_ready; clears on any push, flush, or when m_ready=0.
  - At EMPTY_TIMEOUT: empty_timeout=1 for exactly one cycle, counter returns to 0 and keeps counting.
  - Counter never exceeds EMPTY_TIMEOUT.
- rempty rising while level>0: buffered words still drain normally.
- rempty glitch-free assumption: rempty comes from a registered pointer compare.

Optional Feature:
- Macro: AFIFO_RD_ADAPTER_STATS_EN
- Defined:
  - Adds output rd_count (32 bits, reset 0), +1 per push, wraps 0xFFFF_FFFF->0, cleared by reset only (not flush).
  - Adds output drop_count (16 bits, saturating), +level on each flush.
- Undefined: neither port nor its logic exists; all other behaviour identical.

Decomposition:
- Shared package afifo_rd_pkg:
  - state enum rd_state_t {S_EMPTY, S_ONE, S_TWO}
  - typedef rd_level_t (2 bits)
  - default EMPTY_TIMEOUT constant, aligned with MAX_EMPTY_RETRY in afifo_tb_pkg
- Sub-module: afifo_rd_watchdog (counter, clear/enable inputs, pulse output), reusable on the write side for full stalls.

Test Plan:
- Reset mid-stream: level=2, assert rrst_n=0 -> outputs 0 immediately (asynchronously, without waiting for an rclk edge); release -> no rinc until the first edge with rempty=0.
- Streaming: preload FIFO 0x01..0x10, m_ready=1 -> 16 rinc pulses on consecutive cycles, m_data 0x01..0x10 in order on 16 consecutive cycles, level stays 1.
- Backpressure: m_ready=0, FIFO holds 0xA0..0xA3 -> 2 rincs, level=2, m_data=0xA0 held; m_ready=1 -> 0xA0..0xA3 in order, none lost.
- Flush during pop: level=2 (0x11,0x22), flush=1 with m_ready=1 -> level=0 next cycle, rinc=0 that cycle, next word is the FIFO head 0x33.
- Starvation: rempty=1, m_ready=1, level=0 for 40 cycles, EMPTY_TIMEOUT=16 -> empty_timeout pulses at cycles 16 and 32 only; m_ready=0 for 1 cycle at cycle 10 -> first pulse moves to cycle 27.
- STATS_EN build:
  - 300 words streamed -> rd_count=300.
  - flush at level=2 -> drop_count=2.
  - Build without the macro -> ports absent and the other five scenarios pass unchanged.
